// File: rtl/alu_operand_regfile_pkg.sv
// Shared definitions for the ALU operand register file and the ALU control
// decoder: default datapath widths, ALU control encodings and the index of
// the hardwired zero register.
package alu_operand_regfile_pkg;

    localparam int unsigned DW_DEFAULT    = 8;
    localparam int unsigned AW_DEFAULT    = 3;
    localparam int unsigned NREGS_DEFAULT = 1 << AW_DEFAULT;

    // ALUControl encodings, shared with the ALU control decoder.
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_SLT = 2'b10,
        ALU_SLL = 2'b11
    } alu_ctrl_e;

    // Register 0 always reads as zero and never accepts writes.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/alu_operand_regfile_wb_forward.sv
// Read-port select for one operand: returns zero for the hardwired zero
// register, the pending write-back data when it targets the read address,
// and the stored array value otherwise.
//
// Ports:
//   raddr_i     read address
//   wb_valid_i  write-back buffer holds a pending write
//   wb_addr_i   pending write destination
//   wb_data_i   pending write data
//   arr_data_i  array contents at raddr_i
//   rdata_o     selected operand value
module wb_forward
    import alu_operand_regfile_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic [AW-1:0] raddr_i,
    input  logic          wb_valid_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic [DW-1:0] arr_data_i,
    output logic [DW-1:0] rdata_o
);

    logic is_zero_reg;
    logic fwd_hit;

    assign is_zero_reg = (raddr_i == AW'(ZERO_REG));
    assign fwd_hit     = wb_valid_i && (wb_addr_i == raddr_i);

    always_comb begin
        rdata_o = arr_data_i;
        if (is_zero_reg) begin
            rdata_o = '0;
        end else if (fwd_hit) begin
            rdata_o = wb_data_i;
        end
    end

endmodule

// File: rtl/alu_operand_regfile.sv
// Operand register file for the 8-bit ALU datapath. Sources operands A and B
// combinationally, sinks the ALU result through a one-deep write-back buffer
// whose contents are forwarded to both read ports, keeps a registered Zero
// flag for branch resolution and a per-register "has been written" bitmap.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   ra1, ra2   read addresses for operands A and B
//   rd1, rd2   operands A and B (combinational)
//   we         write request for the ALU result
//   wa, wd     write destination and data
//   alu_ctrl   ALUControl of the current operation
//   zero_in    ALU Zero output
//   zero_flag  Zero flag, loaded on subtract operations
//   written    bit i set once register i has committed a write
module alu_operand_regfile
    import alu_operand_regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned DW    = DW_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [DW-1:0]    rd1,
    output logic [DW-1:0]    rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [DW-1:0]    wd,
    input  logic [1:0]       alu_ctrl,
    input  logic             zero_in,
    output logic             zero_flag,
    output logic [NREGS-1:0] written
);

    logic [DW-1:0]    mem_q [NREGS];
    logic             wb_valid_q, wb_valid_d;
    logic [AW-1:0]    wb_addr_q,  wb_addr_d;
    logic [DW-1:0]    wb_data_q,  wb_data_d;
    logic             zero_flag_q, zero_flag_d;
    logic [NREGS-1:0] written_q;

    // Writes aimed at the zero register are dropped before the buffer, so a
    // valid buffer entry never targets register 0.
    always_comb begin
        wb_valid_d = we && (wa != AW'(ZERO_REG));
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (wb_valid_d) begin
            wb_addr_d = wa;
            wb_data_d = wd;
        end
    end

    always_comb begin
        zero_flag_d = zero_flag_q;
        if (alu_ctrl_e'(alu_ctrl) == ALU_SUB) begin
            zero_flag_d = zero_in;
        end
    end

    // Commit of the previous entry and capture of the new one share an edge,
    // so back-to-back writes stream at one per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            zero_flag_q <= 1'b0;
            written_q   <= '0;
        end else begin
            if (wb_valid_q) begin
                mem_q[wb_addr_q]     <= wb_data_q;
                written_q[wb_addr_q] <= 1'b1;
            end
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            zero_flag_q <= zero_flag_d;
        end
    end

    wb_forward #(
        .AW (AW),
        .DW (DW)
    ) u_fwd_a (
        .raddr_i    (ra1),
        .wb_valid_i (wb_valid_q),
        .wb_addr_i  (wb_addr_q),
        .wb_data_i  (wb_data_q),
        .arr_data_i (mem_q[ra1]),
        .rdata_o    (rd1)
    );

    wb_forward #(
        .AW (AW),
        .DW (DW)
    ) u_fwd_b (
        .raddr_i    (ra2),
        .wb_valid_i (wb_valid_q),
        .wb_addr_i  (wb_addr_q),
        .wb_data_i  (wb_data_q),
        .arr_data_i (mem_q[ra2]),
        .rdata_o    (rd2)
    );

    assign zero_flag = zero_flag_q;
    assign written   = written_q;

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Self-checking bench for alu_operand_regfile: directed scenarios followed by
// randomized write/read/flag traffic against an architectural reference model.
module tb_alu_operand_regfile;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] ra1, ra2, wa;
    logic [7:0] rd1, rd2, wd;
    logic       we;
    logic [1:0] alu_ctrl;
    logic       zero_in;
    logic       zero_flag;
    logic [7:0] written;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model: vis[] is what a read must return (latest accepted
    // write, including one still pending); wr_m is the committed bitmap.
    logic [7:0] vis [8];
    logic [7:0] wr_m;
    logic       zf_m;
    logic       pend_v;
    logic [2:0] pend_a;

    always #5 clock = ~clock;

    alu_operand_regfile #(
        .NREGS (8),
        .AW    (3),
        .DW    (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .alu_ctrl  (alu_ctrl),
        .zero_in   (zero_in),
        .zero_flag (zero_flag),
        .written   (written)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, take the edge, advance the model, settle.
    task automatic cycle(input logic w, input logic [2:0] a, input logic [7:0] d,
                         input logic [1:0] c, input logic z, input logic r);
        we = w; wa = a; wd = d; alu_ctrl = c; zero_in = z; reset = r;
        @(posedge clock);
        if (r) begin
            for (int i = 0; i < 8; i++) vis[i] = 8'h00;
            wr_m   = 8'h00;
            zf_m   = 1'b0;
            pend_v = 1'b0;
        end else begin
            // A write accepted on the previous edge lands in storage on this one.
            if (pend_v) wr_m[pend_a] = 1'b1;
            pend_v = w && (a != 3'd0);
            pend_a = a;
            if (w && (a != 3'd0)) vis[a] = d;
            if (c == 2'b01) zf_m = z;
        end
        #1;
    endtask

    task automatic check_read(input string tag, input logic [2:0] a1, input logic [2:0] a2);
        ra1 = a1; ra2 = a2;
        #1;
        check({tag, ".rd1"}, 32'(rd1), 32'(vis[a1]));
        check({tag, ".rd2"}, 32'(rd2), 32'(vis[a2]));
    endtask

    task automatic check_state(input string tag);
        check({tag, ".zf"}, 32'(zero_flag), 32'(zf_m));
        check({tag, ".written"}, 32'(written), 32'(wr_m));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    initial begin
        ra1 = 3'd0; ra2 = 3'd0;
        pend_v = 1'b0; pend_a = 3'd0; wr_m = 8'h00; zf_m = 1'b0;
        for (int i = 0; i < 8; i++) vis[i] = 8'h00;

        // Reset state.
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b1);
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b1);
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a); ra2 = 3'(7 - a);
            #1;
            check("rst.rd1", 32'(rd1), 32'h00);
            check("rst.rd2", 32'(rd2), 32'h00);
        end
        check("rst.zf", 32'(zero_flag), 32'h0);
        check("rst.written", 32'(written), 32'h00);

        // Forwarded read, then array read after commit.
        cycle(1'b1, 3'd3, 8'h2A, 2'b00, 1'b0, 1'b0);
        ra1 = 3'd3; #1;
        check("fwd.rd1", 32'(rd1), 32'h2A);
        check("fwd.written", 32'(written), 32'h00);
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
        #1;
        check("arr.rd1", 32'(rd1), 32'h2A);
        check("arr.written", 32'(written), 32'h08);

        // Back-to-back writes to r1, both ports reading it.
        cycle(1'b1, 3'd1, 8'h11, 2'b00, 1'b0, 1'b0);
        ra1 = 3'd1; ra2 = 3'd1; #1;
        check("b2b1.rd1", 32'(rd1), 32'h11);
        check("b2b1.rd2", 32'(rd2), 32'h11);
        cycle(1'b1, 3'd1, 8'h22, 2'b00, 1'b0, 1'b0);
        #1;
        check("b2b2.rd1", 32'(rd1), 32'h22);
        check("b2b2.rd2", 32'(rd2), 32'h22);
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
        #1;
        check("b2b_idle.rd1", 32'(rd1), 32'h22);
        check("b2b_idle.rd2", 32'(rd2), 32'h22);

        // Write to the zero register is dropped.
        cycle(1'b1, 3'd0, 8'hFF, 2'b00, 1'b0, 1'b0);
        ra1 = 3'd0; #1;
        check("r0.rd1", 32'(rd1), 32'h00);
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
        #1;
        check("r0.rd1_late", 32'(rd1), 32'h00);
        check("r0.written", 32'(written), 32'h0A);

        // Zero flag loads only on SUB.
        cycle(1'b0, 3'd0, 8'h00, 2'b01, 1'b1, 1'b0);
        check("zf.sub1", 32'(zero_flag), 32'h1);
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
        check("zf.hold", 32'(zero_flag), 32'h1);
        cycle(1'b1, 3'd4, 8'h00, 2'b11, 1'b0, 1'b0);
        check("zf.hold_sll", 32'(zero_flag), 32'h1);
        cycle(1'b0, 3'd0, 8'h00, 2'b01, 1'b0, 1'b0);
        check("zf.sub0", 32'(zero_flag), 32'h0);

        // Reset discards a pending write.
        cycle(1'b0, 3'd0, 8'h00, 2'b01, 1'b1, 1'b0);
        cycle(1'b1, 3'd5, 8'h77, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b1);
        ra1 = 3'd5; ra2 = 3'd1; #1;
        check("rstpend.rd1", 32'(rd1), 32'h00);
        check("rstpend.rd2", 32'(rd2), 32'h00);
        check("rstpend.written", 32'(written), 32'h00);
        check("rstpend.zf", 32'(zero_flag), 32'h0);
        cycle(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
        #1;
        check("rstpend.rd1_late", 32'(rd1), 32'h00);
        check("rstpend.written_late", 32'(written), 32'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic       w, z, r;
            logic [2:0] a;
            logic [7:0] d;
            logic [1:0] c;
            w = ($urandom_range(0, 3) != 0);
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            c = 2'($urandom_range(0, 3));
            z = 1'($urandom);
            r = ($urandom_range(0, 49) == 0);
            cycle(w, a, d, c, z, r);
            if ($urandom_range(0, 1) == 1) check_read("rnd", a, a);
            else check_read("rnd", 3'($urandom), 3'($urandom));
            check_state("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
